// File: rtl/burst_reader.sv
// burst_reader: streams a word burst from a 1-cycle-latency RAM into a small credit-limited output FIFO.
// Define BURST_READER_HALF_SWAP_EN to swap the 16-bit halves of every output word.
module burst_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  io_start,
  input  logic [ADDR_WIDTH-1:0] io_base,
  input  logic [ADDR_WIDTH:0]   io_len,
  output logic                  io_busy,
  output logic                  io_done,
  output logic [ADDR_WIDTH-1:0] io_ram_addr,
  input  logic [DATA_WIDTH-1:0] io_ram_dout,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [DATA_WIDTH-1:0] io_out_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} stateT;
  stateT state;
  logic [ADDR_WIDTH:0] remaining;
  logic inFlight;
  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0] count;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] word;
  logic issue, pop;
  // in-flight reads reserve a slot so the FIFO can never overflow
  assign issue = state == BURST && count + (PW+1)'(inFlight) < (PW+1)'(FIFO_DEPTH);
  assign pop = io_out_valid && io_out_ready;
  assign io_out_valid = count != '0;
  assign word = mem[rdPtr];
`ifdef BURST_READER_HALF_SWAP_EN
  assign io_out_data = {word[DATA_WIDTH/2-1:0], word[DATA_WIDTH-1:DATA_WIDTH/2]};
`else
  assign io_out_data = word;
`endif
  always_ff @(posedge clock)
    if (inFlight) mem[wrPtr] <= io_ram_dout;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      io_busy <= 1'b0;
      io_done <= 1'b0;
      io_ram_addr <= '0;
      remaining <= '0;
      inFlight <= 1'b0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      io_done <= 1'b0;
      inFlight <= issue;
      if (inFlight) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + (PW+1)'(inFlight) - (PW+1)'(pop);
      if (issue) begin
        io_ram_addr <= io_ram_addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
      case (state)
        IDLE:
          if (io_start && io_len == '0) io_done <= 1'b1;
          else if (io_start) begin
            io_ram_addr <= io_base;
            remaining <= io_len;
            io_busy <= 1'b1;
            state <= BURST;
          end
        BURST:
          if (issue && remaining == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
        DRAIN:
          if (pop && !inFlight && count == (PW+1)'(1)) begin
            io_busy <= 1'b0;
            io_done <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
